// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the EXE-stage multiply/divide sequencer.
package muldiv_sequencer_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE     = 3'd0,
        SEQ_MUL      = 3'd1,
        SEQ_DIV_INIT = 3'd2,
        SEQ_DIV_RUN  = 3'd3,
        SEQ_DONE     = 3'd4
    } seq_state_e;

    localparam logic [1:0]  MUL_STATE_IDLE = 2'd0;

    localparam int unsigned DEF_MUL_STAGES = 3;
    localparam int unsigned DEF_DIV_STEPS  = 32;
    localparam int unsigned DEF_CNT_W      = 6;

endpackage

// File: rtl/muldiv_sequencer.sv
// Sequences the multi-cycle multiply/divide paths of the EXE-stage ALU and
// stalls the front of the pipe until the result is valid.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned MUL_STAGES = DEF_MUL_STAGES,
    parameter int unsigned DIV_STEPS  = DEF_DIV_STEPS,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       op_valid_i,
    input  logic       op_is_div_i,
    input  logic       flush_i,
    input  logic       freeze_i,
    output logic [1:0] mul_state_o,
    output logic       d_init_o,
    output logic       d_advance_o,
    output logic       div_last_o,
    output logic       stall_o,
    output logic       done_o,
    output logic       busy_o
);

    // Truncation is intentional: with DIV_STEPS == 2**CNT_W the counter wraps
    // to zero exactly on the final step, so the compare still fires there.
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STAGES);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_STEPS);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // State and step counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEQ_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode; freeze holds state and suppresses strobes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mul_state_o = MUL_STATE_IDLE;
        d_init_o    = 1'b0;
        d_advance_o = 1'b0;
        div_last_o  = 1'b0;
        stall_o     = 1'b0;
        done_o      = 1'b0;

        if (reset) begin
            state_d = SEQ_IDLE;
            cnt_d   = '0;
        end else if (flush_i) begin
            state_d = SEQ_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                SEQ_IDLE: begin
                    if (op_valid_i && !freeze_i) begin
                        stall_o = 1'b1;
                        if (op_is_div_i) begin
                            // Start cycle doubles as the divider init cycle.
                            d_init_o = 1'b1;
                            state_d  = SEQ_DIV_RUN;
                            cnt_d    = CNT_W'(1);
                        end else begin
                            mul_state_o = 2'd1;
                            if (MUL_STAGES == 1) begin
                                state_d = SEQ_DONE;
                                cnt_d   = '0;
                            end else begin
                                state_d = SEQ_MUL;
                                cnt_d   = CNT_W'(2);
                            end
                        end
                    end
                end
                SEQ_MUL: begin
                    mul_state_o = cnt_q[1:0];
                    stall_o     = 1'b1;
                    if (!freeze_i) begin
                        if (cnt_q == MUL_LAST) begin
                            state_d = SEQ_DONE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                SEQ_DIV_INIT: begin
                    stall_o = 1'b1;
                    if (!freeze_i) begin
                        d_init_o = 1'b1;
                        state_d  = SEQ_DIV_RUN;
                        cnt_d    = CNT_W'(1);
                    end
                end
                SEQ_DIV_RUN: begin
                    stall_o = 1'b1;
                    if (!freeze_i) begin
                        d_advance_o = 1'b1;
                        div_last_o  = (cnt_q == DIV_LAST);
                        if (cnt_q == DIV_LAST) begin
                            state_d = SEQ_DONE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                SEQ_DONE: begin
                    done_o = 1'b1;
                    if (!freeze_i) begin
                        state_d = SEQ_IDLE;
                    end
                end
                default: begin
                    state_d = SEQ_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign busy_o = (state_q != SEQ_IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: per-cycle output vectors plus a
// scoreboard of expected completion cycles.
module tb_muldiv_sequencer;

    localparam int unsigned MS = 3;
    localparam int unsigned DS = 32;
    localparam int unsigned CW = 6;

    logic       clk = 1'b0;
    logic       reset, op_valid_i, op_is_div_i, flush_i, freeze_i;
    logic [1:0] mul_state_o;
    logic       d_init_o, d_advance_o, div_last_o, stall_o, done_o, busy_o;
    logic [7:0] obs;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int sb[$];

    muldiv_sequencer #(.MUL_STAGES(MS), .DIV_STEPS(DS), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid_i  (op_valid_i),
        .op_is_div_i (op_is_div_i),
        .flush_i     (flush_i),
        .freeze_i    (freeze_i),
        .mul_state_o (mul_state_o),
        .d_init_o    (d_init_o),
        .d_advance_o (d_advance_o),
        .div_last_o  (div_last_o),
        .stall_o     (stall_o),
        .done_o      (done_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    assign obs = {mul_state_o, d_init_o, d_advance_o, div_last_o, stall_o, done_o, busy_o};

    function automatic logic [7:0] ev(input logic [1:0] ms, input logic ini, input logic adv,
                                      input logic last, input logic stall, input logic done,
                                      input logic busy);
        return {ms, ini, adv, last, stall, done, busy};
    endfunction

    // Drive one cycle's inputs just after the edge; return at the sampling point.
    task automatic step(input logic rst, input logic v, input logic d, input logic fl, input logic fr);
        @(posedge clk);
        #1;
        reset = rst; op_valid_i = v; op_is_div_i = d; flush_i = fl; freeze_i = fr;
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        for (int t = 0; t < 3; t++) begin
            step(t < 2, 1'b1 && (t < 2), t[0], 1'b0, 1'b0);
            e = ev(2'd0, 0, 0, 0, 0, 0, 0);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL reset t=%0d got=%b expected=%b", t, obs, e);
            end
        end
    endtask

    task automatic test_mul();
        logic [7:0] e;
        int exp_done;
        for (int t = 0; t <= 4; t++) begin
            step(0, t == 0, 0, 0, 0);
            if (t == 0) sb.push_back(cyc + int'(MS));
            case (t)
                0:       e = ev(2'd1, 0, 0, 0, 1, 0, 0);
                1, 2:    e = ev(2'(t + 1), 0, 0, 0, 1, 0, 1);
                3:       e = ev(2'd0, 0, 0, 0, 0, 1, 1);
                default: e = ev(2'd0, 0, 0, 0, 0, 0, 0);
            endcase
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL mul t=%0d got=%b expected=%b", t, obs, e);
            end
            if (done_o) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL mul_sb unexpected done at cyc %0d", cyc);
                end else begin
                    exp_done = sb.pop_front();
                    if (cyc !== exp_done) begin
                        miscompares++;
                        $display("FAIL mul_latency done cyc=%0d expected=%0d", cyc, exp_done);
                    end
                end
            end
        end
    endtask

    task automatic test_div();
        logic [7:0] e;
        int exp_done;
        int pulses = 0;
        for (int t = 0; t <= 34; t++) begin
            // op_valid stays high and op_is_div toggles while busy: both ignored
            step(0, t <= 32, (t == 0) ? 1'b1 : t[0], 0, 0);
            if (t == 0) sb.push_back(cyc + int'(DS) + 1);
            if (t == 0)               e = ev(2'd0, 1, 0, 0, 1, 0, 0);
            else if (t <= int'(DS))   e = ev(2'd0, 0, 1, t == int'(DS), 1, 0, 1);
            else if (t == int'(DS)+1) e = ev(2'd0, 0, 0, 0, 0, 1, 1);
            else                      e = ev(2'd0, 0, 0, 0, 0, 0, 0);
            pulses += int'(d_advance_o);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL div t=%0d got=%b expected=%b", t, obs, e);
            end
            if (done_o) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL div_sb unexpected done at cyc %0d", cyc);
                end else begin
                    exp_done = sb.pop_front();
                    if (cyc !== exp_done) begin
                        miscompares++;
                        $display("FAIL div_latency done cyc=%0d expected=%0d", cyc, exp_done);
                    end
                end
            end
        end
        vectors++;
        if (pulses !== int'(DS)) begin
            miscompares++;
            $display("FAIL div_pulses got=%0d expected=%0d", pulses, DS);
        end
    endtask

    task automatic test_flush();
        logic [7:0] e;
        int exp_done;
        for (int t = 0; t <= 16; t++) begin
            case (t)
                0:       step(0, 1, 1, 0, 0);
                10:      step(0, 1, 1, 1, 1);   // flush wins over freeze
                11:      step(0, 1, 0, 1, 0);   // flush in IDLE blocks a start
                12:      step(0, 1, 0, 0, 0);
                default: step(0, t < 10, 1, 0, 0);
            endcase
            if (t == 0)  sb.push_back(cyc + int'(DS) + 1);
            if (t == 10 && sb.size() > 0) void'(sb.pop_front());
            if (t == 12) sb.push_back(cyc + int'(MS));
            if (t == 0)                   e = ev(2'd0, 1, 0, 0, 1, 0, 0);
            else if (t < 10)              e = ev(2'd0, 0, 1, 0, 1, 0, 1);
            else if (t == 10)             e = ev(2'd0, 0, 0, 0, 0, 0, 1);
            else if (t == 11)             e = ev(2'd0, 0, 0, 0, 0, 0, 0);
            else if (t == 12)             e = ev(2'd1, 0, 0, 0, 1, 0, 0);
            else if (t == 13 || t == 14)  e = ev(2'(t - 11), 0, 0, 0, 1, 0, 1);
            else if (t == 15)             e = ev(2'd0, 0, 0, 0, 0, 1, 1);
            else                          e = ev(2'd0, 0, 0, 0, 0, 0, 0);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL flush t=%0d got=%b expected=%b", t, obs, e);
            end
            if (done_o) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL flush_sb unexpected done at cyc %0d", cyc);
                end else begin
                    exp_done = sb.pop_front();
                    if (cyc !== exp_done) begin
                        miscompares++;
                        $display("FAIL flush_latency done cyc=%0d expected=%0d", cyc, exp_done);
                    end
                end
            end
        end
    endtask

    task automatic test_freeze();
        logic [7:0] e;
        int exp_done;
        int pulses = 0;
        step(0, 1, 1, 0, 0);
        sb.push_back(cyc + int'(DS) + 1 + 3);
        e = ev(2'd0, 1, 0, 0, 1, 0, 0);
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL freeze_init got=%b expected=%b", obs, e);
        end
        for (int c = 1; c <= int'(DS); c++) begin
            if (c == 5) begin
                for (int f = 0; f < 3; f++) begin
                    step(0, 0, 0, 0, 1);
                    e = ev(2'd0, 0, 0, 0, 1, 0, 1);
                    pulses += int'(d_advance_o);
                    vectors++;
                    if (obs !== e) begin
                        miscompares++;
                        $display("FAIL freeze_hold f=%0d got=%b expected=%b", f, obs, e);
                    end
                end
            end
            step(0, 0, 0, 0, 0);
            e = ev(2'd0, 0, 1, c == int'(DS), 1, 0, 1);
            pulses += int'(d_advance_o);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL freeze_run c=%0d got=%b expected=%b", c, obs, e);
            end
        end
        vectors++;
        if (pulses !== int'(DS)) begin
            miscompares++;
            $display("FAIL freeze_pulses got=%0d expected=%0d", pulses, DS);
        end
        // DONE frozen for two cycles, then released
        for (int t = 0; t < 3; t++) begin
            step(0, 0, 0, 0, t < 2);
            e = ev(2'd0, 0, 0, 0, 0, 1, 1);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL freeze_done t=%0d got=%b expected=%b", t, obs, e);
            end
            if (t == 0) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL freeze_sb empty at done cyc %0d", cyc);
                end else begin
                    exp_done = sb.pop_front();
                    if (!(done_o === 1'b1 && cyc == exp_done)) begin
                        miscompares++;
                        $display("FAIL freeze_latency done=%b cyc=%0d expected=%0d", done_o, cyc, exp_done);
                    end
                end
            end
        end
        // freeze in IDLE must block a start; nothing may be latched
        for (int t = 0; t < 3; t++) begin
            step(0, t == 0, 0, 0, t == 0);
            e = ev(2'd0, 0, 0, 0, 0, 0, 0);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL freeze_idle t=%0d got=%b expected=%b", t, obs, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        int exp_done;
        int dones = 0;
        for (int t = 0; t <= 38; t++) begin
            // op_valid with div already presented during mul DONE: must wait for IDLE
            step(0, t == 0 || t == 3 || t == 4, t >= 3, 0, 0);
            if (t == 0) sb.push_back(cyc + int'(MS));
            if (t == 4) sb.push_back(cyc + int'(DS) + 1);
            if (t == 0)                    e = ev(2'd1, 0, 0, 0, 1, 0, 0);
            else if (t <= 2)               e = ev(2'(t + 1), 0, 0, 0, 1, 0, 1);
            else if (t == 3)               e = ev(2'd0, 0, 0, 0, 0, 1, 1);
            else if (t == 4)               e = ev(2'd0, 1, 0, 0, 1, 0, 0);
            else if (t <= 4 + int'(DS))    e = ev(2'd0, 0, 1, t == 4 + int'(DS), 1, 0, 1);
            else if (t == 5 + int'(DS))    e = ev(2'd0, 0, 0, 0, 0, 1, 1);
            else                           e = ev(2'd0, 0, 0, 0, 0, 0, 0);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL b2b t=%0d got=%b expected=%b", t, obs, e);
            end
            if (done_o) begin
                dones++;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_sb unexpected done at cyc %0d", cyc);
                end else begin
                    exp_done = sb.pop_front();
                    if (cyc !== exp_done) begin
                        miscompares++;
                        $display("FAIL b2b_latency done cyc=%0d expected=%0d", cyc, exp_done);
                    end
                end
            end
        end
        vectors++;
        if (dones !== 2) begin
            miscompares++;
            $display("FAIL b2b_done_count got=%0d expected=2", dones);
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [7:0] e;
        step(0, 1, 0, 0, 0);
        sb.push_back(cyc + int'(MS));
        step(0, 0, 0, 0, 0);
        e = ev(2'd2, 0, 0, 0, 1, 0, 1);
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL rstmul_pre got=%b expected=%b", obs, e);
        end
        step(1, 0, 0, 0, 0);
        if (sb.size() > 0) void'(sb.pop_front());
        for (int t = 0; t < 2; t++) begin
            step(0, 0, 0, 0, 0);
            e = ev(2'd0, 0, 0, 0, 0, 0, 0);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL rstmul_post t=%0d got=%b expected=%b", t, obs, e);
            end
        end
    endtask

    initial begin
        reset = 1'b1; op_valid_i = 1'b0; op_is_div_i = 1'b0; flush_i = 1'b0; freeze_i = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_flush();
        test_freeze();
        test_back_to_back();
        test_reset_mid_mul();
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL sb_leftover got=%0d expected=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
